apu_multi_voice: RTL

Parametrised multi-voice successor to the single-voice audio processing unit. It runs `NUM_CH` independent oscillator voices, each selectable as saw, square or noise. Each voice has its own period, its own decaying envelope and its own trigger. The voices are summed in a mixer that drives a 1-bit PWM `sound` output for the board's audio pin. A config port sits on the game-logic side; `frame_tick` comes from the video timing (start of frame).

---
 rtl/apu_pkg.sv | 16 +
 rtl/apu_multi_voice_if.sv | 17 +
 rtl/apu_voice.sv | 95 +++++++++
 rtl/apu_multi_voice.sv | 70 +++++++
 4 files changed

// File: rtl/apu_pkg.sv
// rtl/apu_pkg.sv - shared mode codes and noise LFSR definition for the multi-voice APU
package apu_pkg;
  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SAW    = 2'd1;
  localparam logic [1:0] MODE_SQUARE = 2'd2;
  localparam logic [1:0] MODE_NOISE  = 2'd3;

  localparam int          LFSR_W    = 13;
  localparam logic [12:0] LFSR_SEED = 13'h0E1F;
  // feedback taps at bits 12, 3, 2 and 0
  localparam logic [12:0] LFSR_TAPS = 13'h100D;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/apu_multi_voice_if.sv
// rtl/apu_multi_voice_if.sv - voice configuration write port
interface apu_multi_voice_if #(
  parameter int NUM_CH      = 4,
  parameter int PERIOD_BITS = 16,
  parameter int ENV_BITS    = 5
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                   cfg_we;
  logic [CH_W-1:0]        cfg_ch;
  logic [PERIOD_BITS-1:0] cfg_period;
  logic [1:0]             cfg_mode;
  logic [ENV_BITS-1:0]    cfg_decay;

  modport master (output cfg_we, cfg_ch, cfg_period, cfg_mode, cfg_decay);
  modport slave  (input  cfg_we, cfg_ch, cfg_period, cfg_mode, cfg_decay);
endinterface

// File: rtl/apu_voice.sv
// rtl/apu_voice.sv - one voice: config, phase oscillator, envelope and sample register
module apu_voice
  import apu_pkg::*;
#(
  parameter int PERIOD_BITS = 16,
  parameter int LOG2_STEP   = 2,
  parameter int PWM_BITS    = 8,
  parameter int ENV_BITS    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   we,
  input  logic [PERIOD_BITS-1:0] cfg_period,
  input  logic [1:0]             cfg_mode,
  input  logic [ENV_BITS-1:0]    cfg_decay,
  input  logic                   trigger,
  input  logic                   frame_tick,
  input  logic                   lfsr_bit,
  output logic [ENV_BITS-1:0]    env,
  output logic [PWM_BITS-1:0]    sample
);
  localparam logic [PERIOD_BITS:0] STEP = (PERIOD_BITS+1)'(1) << LOG2_STEP;

  logic [PERIOD_BITS-1:0]       period;
  logic [PERIOD_BITS-1:0]       phase;
  logic [1:0]                   mode;
  logic [ENV_BITS-1:0]          decay;
  logic                         sq;
  logic                         noise_bit;
  logic                         wrap;
  logic [PERIOD_BITS:0]         reload;
  logic [PWM_BITS-1:0]          w;
  logic [PWM_BITS+ENV_BITS-1:0] prod;

  assign wrap   = ~|phase[PERIOD_BITS-1:LOG2_STEP];
  assign reload = {1'b0, phase} + {1'b0, period};

  always_ff @(posedge clk) begin
    if (reset) begin
      period <= '0;
      mode   <= MODE_OFF;
      decay  <= '0;
    end else if (we) begin
      period <= cfg_period;
      mode   <= cfg_mode;
      decay  <= cfg_decay;
    end
  end

  // Periods shorter than one step clamp the reload at 0 so the voice wraps every clock
  always_ff @(posedge clk) begin
    if (reset) begin
      phase     <= '0;
      sq        <= 1'b0;
      noise_bit <= 1'b0;
    end else begin
      if (mode != MODE_OFF) begin
        if (wrap) begin
          phase     <= (reload < STEP) ? '0 : PERIOD_BITS'(reload - STEP);
          sq        <= ~sq;
          noise_bit <= lfsr_bit;
        end else begin
          phase <= phase - STEP[PERIOD_BITS-1:0];
        end
      end
      if (trigger) begin
        phase <= '0;
        sq    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)           env <= '0;
    else if (trigger)    env <= '1;
    else if (frame_tick) env <= (env > decay) ? env - decay : '0;
  end

  always_comb begin
    w = '0;
    case (mode)
      MODE_SAW:    w = phase[PERIOD_BITS-1 -: PWM_BITS];
      MODE_SQUARE: w = {PWM_BITS{sq}};
      MODE_NOISE:  w = {PWM_BITS{noise_bit}};
      default:     w = '0;
    endcase
  end

  assign prod = {{ENV_BITS{1'b0}}, w} * {{PWM_BITS{1'b0}}, env};

  always_ff @(posedge clk) begin
    if (reset) sample <= '0;
    else       sample <= PWM_BITS'(prod >> ENV_BITS);
  end
endmodule

// File: rtl/apu_multi_voice.sv
// rtl/apu_multi_voice.sv - multi-voice APU top: shared LFSR, voice array, mixer and PWM output
module apu_multi_voice
  import apu_pkg::*;
#(
  parameter int  NUM_CH      = 4,
  parameter int  PERIOD_BITS = 16,
  parameter int  LOG2_STEP   = 2,
  parameter int  PWM_BITS    = 8,
  parameter int  ENV_BITS    = 5,
  localparam int MIX_W       = PWM_BITS + $clog2(NUM_CH)
) (
  input  logic                clk,
  input  logic                reset,
  apu_multi_voice_if.slave    cfg,
  input  logic [NUM_CH-1:0]   trigger,
  input  logic                frame_tick,
  output logic [NUM_CH-1:0]   active,
  output logic [MIX_W-1:0]    mix,
  output logic                sound
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [LFSR_W-1:0]   lfsr;
  logic [MIX_W-1:0]    pwm_cnt;
  logic [MIX_W-1:0]    sum;
  logic [ENV_BITS-1:0] env [NUM_CH];
  logic [PWM_BITS-1:0] smp [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
    apu_voice #(
      .PERIOD_BITS (PERIOD_BITS),
      .LOG2_STEP   (LOG2_STEP),
      .PWM_BITS    (PWM_BITS),
      .ENV_BITS    (ENV_BITS)
    ) u_voice (
      .clk        (clk),
      .reset      (reset),
      .we         (cfg.cfg_we && (cfg.cfg_ch == CH_W'(i))),
      .cfg_period (cfg.cfg_period),
      .cfg_mode   (cfg.cfg_mode),
      .cfg_decay  (cfg.cfg_decay),
      .trigger    (trigger[i]),
      .frame_tick (frame_tick),
      .lfsr_bit   (lfsr[0]),
      .env        (env[i]),
      .sample     (smp[i])
    );
    assign active[i] = |env[i];
  end

  // MIX_W carries $clog2(NUM_CH) guard bits, so the sum cannot overflow
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) sum = sum + MIX_W'(smp[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr    <= LFSR_SEED;
      pwm_cnt <= '0;
      mix     <= '0;
      sound   <= 1'b0;
    end else begin
      lfsr    <= lfsr_next(lfsr);
      pwm_cnt <= pwm_cnt + MIX_W'(1);
      mix     <= sum;
      sound   <= (pwm_cnt < mix);
    end
  end
endmodule
